// File: rtl/abus_if.sv
// Address-bus interface between the microcode sequencer (master) and abus_gen (slave).
// Carries the operand/control strobes in and the generated addresses, PC and status out.
interface abus_if #(
  parameter int DW = 8
);
  localparam int AW = 2 * DW;

  logic [DW-1:0] DB;
  logic [DW-1:0] REG;
  logic          CI;
  logic [2:0]    op;
  logic [2:0]    hop;
  logic          fix_en;
  logic          ld_ahl;
  logic          ld_pc;
  logic          inc_pc;

  logic [AW-1:0] AB;
  logic [AW-1:0] ABR;
  logic [AW-1:0] PC;
  logic [DW-1:0] AHL;
  logic          stall;
  logic          pc_wrap;

  modport master (
    output DB, REG, CI, op, hop, fix_en, ld_ahl, ld_pc, inc_pc,
    input  AB, ABR, PC, AHL, stall, pc_wrap
  );

  modport slave (
    input  DB, REG, CI, op, hop, fix_en, ld_ahl, ld_pc, inc_pc,
    output AB, ABR, PC, AHL, stall, pc_wrap
  );
endinterface

// File: rtl/abus_gen.sv
// Full-width address generator: low/high half adders, PC with wrap flag, one-cycle page-cross fixup.
// Optional macro ABUS_ZP_WRAP_EN: op=011 wraps within page 0 (ADH=0, no carry, no fixup).
module abus_gen #(
  parameter int              DW         = 8,
  parameter logic [DW-1:0]   STACK_PAGE = DW'(8'h01),
  parameter logic [2*DW-1:0] RST_ADDR   = (2*DW)'(16'hFFFC)
) (
  input logic  clk,
  input logic  rst_n,
  abus_if.slave bus
);
  localparam int AW = 2 * DW;

  typedef enum logic {
    IDLE = 1'b0,
    FIX  = 1'b1
  } state_t;

  state_t        state_reg;
  logic [AW-1:0] abr_reg;
  logic [AW-1:0] pc_reg;
  logic [DW-1:0] ahl_reg;
  logic          stall_reg;
  logic          pc_wrap_reg;

  logic [DW-1:0] abr_lo;
  logic [DW-1:0] abr_hi;
  logic [DW-1:0] lo_base;
  logic [DW-1:0] lo_off;
  logic [DW:0]   lo_sum;
  logic          col;
  logic [DW-1:0] adl;
  logic [DW-1:0] hbase;
  logic          c_hi;
  logic          fix_go;
  logic          zp_force;
  logic [DW-1:0] adh;
  logic [AW-1:0] ab_next;
  logic [AW:0]   pc_sum;

  assign abr_lo = abr_reg[DW-1:0];
  assign abr_hi = abr_reg[AW-1:DW];

  // Low half: base + offset + CI over DW+1 bits, carry-out becomes COL
  always_comb begin
    lo_base = '0;
    lo_off  = '0;
    case (bus.op)
      3'b000, 3'b100: lo_base = pc_reg[DW-1:0];
      3'b001, 3'b101: lo_off  = bus.REG;
      3'b010: begin
        lo_base = bus.DB;
        lo_off  = abr_lo;
      end
      3'b110: lo_off = abr_lo;
      3'b011: begin
        lo_base = bus.DB;
        lo_off  = bus.REG;
      end
      3'b111: begin
        lo_base = ahl_reg;
        lo_off  = bus.REG;
      end
      default: ;
    endcase
    lo_sum = {1'b0, lo_base} + {1'b0, lo_off} + {{DW{1'b0}}, bus.CI};
    col    = lo_sum[DW];
    adl    = lo_sum[DW-1:0];
  end

  always_comb begin
    hbase = pc_reg[AW-1:DW];
    case (bus.hop)
      3'b001:  hbase = STACK_PAGE;
      3'b010:  hbase = abr_hi;
      3'b011:  hbase = bus.DB;
      3'b100:  hbase = '0;
      default: hbase = pc_reg[AW-1:DW];
    endcase

    c_hi     = col;
    fix_go   = 1'b0;
    zp_force = 1'b0;
    if (bus.hop == 3'b001) begin
      c_hi = 1'b0;
    end
    // Deferred fixup: emit the un-carried page now, repair the high half next cycle
    if (state_reg == IDLE && bus.fix_en && bus.op[1:0] == 2'b11) begin
      c_hi   = 1'b0;
      fix_go = col;
    end
`ifdef ABUS_ZP_WRAP_EN
    if (bus.op == 3'b011) begin
      c_hi     = 1'b0;
      fix_go   = 1'b0;
      zp_force = 1'b1;
    end
`endif
    adh = zp_force ? '0 : (hbase + {{(DW-1){1'b0}}, c_hi});

    if (state_reg == FIX) begin
      ab_next = {abr_hi + DW'(1), abr_lo};
    end else begin
      ab_next = {adh, adl};
    end
  end

  assign pc_sum = {1'b0, abr_reg} + {{AW{1'b0}}, bus.inc_pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      abr_reg     <= RST_ADDR;
      pc_reg      <= '0;
      ahl_reg     <= '0;
      stall_reg   <= 1'b0;
      pc_wrap_reg <= 1'b0;
    end else begin
      abr_reg     <= ab_next;
      pc_wrap_reg <= 1'b0;
      if (bus.ld_ahl) begin
        ahl_reg <= bus.DB;
      end
      // Carry out of the AW-bit add is exactly the all-ones + increment case
      if (state_reg == IDLE && bus.ld_pc) begin
        pc_reg      <= pc_sum[AW-1:0];
        pc_wrap_reg <= pc_sum[AW];
      end
      case (state_reg)
        IDLE: begin
          if (fix_go) begin
            state_reg <= FIX;
            stall_reg <= 1'b1;
          end else begin
            stall_reg <= 1'b0;
          end
        end
        FIX: begin
          state_reg <= IDLE;
          stall_reg <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          stall_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.AB      = ab_next;
  assign bus.ABR     = abr_reg;
  assign bus.PC      = pc_reg;
  assign bus.AHL     = ahl_reg;
  assign bus.stall   = stall_reg;
  assign bus.pc_wrap = pc_wrap_reg;

endmodule

// File: tb/tb_abus_gen.sv
// Directed bench for abus_gen: expectations are queued when stimulus is driven and
// popped when the corresponding DUT output is sampled.
module tb_abus_gen;
  logic clk;
  logic rst_n;

  abus_if #(.DW(8)) bus ();

  abus_gen #(
    .DW(8),
    .STACK_PAGE(8'h01),
    .RST_ADDR(16'hFFFC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  task automatic expect_val(input string tag, input logic [15:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [15:0] observed);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty observed=%h expected=none", observed);
    end else begin
      e = exp_q.pop_front();
      assert (observed === e.value)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
      end
      $display("vec %0d %s observed=%h expected=%h", vectors, e.tag, observed, e.value);
    end
  endtask

  // Advance one clock and settle away from the active edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.DB      = '0;
    bus.REG     = '0;
    bus.CI      = 1'b0;
    bus.op      = 3'b000;
    bus.hop     = 3'b000;
    bus.fix_en  = 1'b0;
    bus.ld_ahl  = 1'b0;
    bus.ld_pc   = 1'b0;
    bus.inc_pc  = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Reset state
    expect_val("rst_abr", 16'hFFFC);   check(bus.ABR);
    expect_val("rst_pc", 16'h0000);    check(bus.PC);
    expect_val("rst_ahl", 16'h0000);   check({8'h00, bus.AHL});
    expect_val("rst_stall", 16'h0000); check({15'd0, bus.stall});
    expect_val("rst_wrap", 16'h0000);  check({15'd0, bus.pc_wrap});

    // Stack access
    rst_n   = 1'b1;
    bus.op  = 3'b001;
    bus.hop = 3'b001;
    bus.REG = 8'hFD;
    expect_val("stack_ab", 16'h01FD);
    #1 check(bus.AB);
    expect_val("stack_abr", 16'h01FD);
    tick(); check(bus.ABR);

    // Load AHL
    bus.DB     = 8'hF0;
    bus.ld_ahl = 1'b1;
    expect_val("ahl_load", 16'h00F0);
    tick(); check({8'h00, bus.AHL});
    bus.ld_ahl = 1'b0;

    // Abs+index without fixup: carry goes straight into the high half
    bus.DB     = 8'h12;
    bus.REG    = 8'h20;
    bus.op     = 3'b111;
    bus.hop    = 3'b011;
    bus.fix_en = 1'b0;
    expect_val("absx_nofix_ab", 16'h1310);
    #1 check(bus.AB);
    expect_val("absx_nofix_stall", 16'h0000);
    expect_val("absx_nofix_abr", 16'h1310);
    tick(); check({15'd0, bus.stall}); check(bus.ABR);

    // Abs+index with fixup
    bus.fix_en = 1'b1;
    expect_val("absx_fix_ab_n", 16'h1210);
    #1 check(bus.AB);
    expect_val("absx_fix_stall_n1", 16'h0001);
    expect_val("absx_fix_abr_n1", 16'h1210);
    tick(); check({15'd0, bus.stall}); check(bus.ABR);
    bus.op     = 3'b001;
    bus.hop    = 3'b100;
    bus.fix_en = 1'b0;
    expect_val("absx_fix_ab_n1", 16'h1310);
    #1 check(bus.AB);
    expect_val("absx_fix_stall_n2", 16'h0000);
    expect_val("absx_fix_abr_n2", 16'h1310);
    tick(); check({15'd0, bus.stall}); check(bus.ABR);
    expect_val("after_fix_ab", 16'h0020);
    check(bus.AB);

    // PC wrap from all-ones
    bus.op  = 3'b001;
    bus.hop = 3'b011;
    bus.DB  = 8'hFF;
    bus.REG = 8'hFF;
    expect_val("abr_ffff", 16'hFFFF);
    tick(); check(bus.ABR);
    bus.ld_pc  = 1'b1;
    bus.inc_pc = 1'b1;
    expect_val("wrap_pc", 16'h0000);
    expect_val("wrap_flag", 16'h0001);
    tick(); check(bus.PC); check({15'd0, bus.pc_wrap});
    bus.ld_pc = 1'b0;
    expect_val("wrap_flag_clear", 16'h0000);
    tick(); check({15'd0, bus.pc_wrap});

    // PC increment across a page, no wrap
    bus.DB  = 8'h12;
    bus.REG = 8'hFF;
    expect_val("abr_12ff", 16'h12FF);
    tick(); check(bus.ABR);
    bus.ld_pc = 1'b1;
    expect_val("inc_pc", 16'h1300);
    expect_val("inc_flag", 16'h0000);
    tick(); check(bus.PC); check({15'd0, bus.pc_wrap});
    bus.ld_pc  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.op     = 3'b000;
    bus.hop    = 3'b000;
    bus.CI     = 1'b1;
    expect_val("pc_fetch_ab", 16'h1301);
    #1 check(bus.AB);
    bus.CI = 1'b0;

    // Reset during the FIX cycle
    bus.DB     = 8'h12;
    bus.REG    = 8'h20;
    bus.op     = 3'b111;
    bus.hop    = 3'b011;
    bus.fix_en = 1'b1;
    expect_val("midfix_stall", 16'h0001);
    tick(); check({15'd0, bus.stall});
    rst_n = 1'b0;
    expect_val("midfix_rst_stall", 16'h0000);
    expect_val("midfix_rst_abr", 16'hFFFC);
    expect_val("midfix_rst_pc", 16'h0000);
    #1 check({15'd0, bus.stall}); check(bus.ABR); check(bus.PC);
    tick();
    rst_n      = 1'b1;
    bus.op     = 3'b001;
    bus.hop    = 3'b001;
    bus.REG    = 8'hFD;
    bus.fix_en = 1'b0;
    expect_val("post_rst_ab", 16'h01FD);
    #1 check(bus.AB);
    expect_val("post_rst_stall", 16'h0000);
    expect_val("post_rst_abr", 16'h01FD);
    tick(); check({15'd0, bus.stall}); check(bus.ABR);

    // Zero-page indexing
    bus.DB     = 8'hF0;
    bus.REG    = 8'h20;
    bus.op     = 3'b011;
    bus.hop    = 3'b100;
    bus.fix_en = 1'b1;
    expect_val("zp_ab", 16'h0010);
    #1 check(bus.AB);
`ifdef ABUS_ZP_WRAP_EN
    expect_val("zp_stall", 16'h0000);
    expect_val("zp_ab_next", 16'h0010);
`else
    expect_val("zp_stall", 16'h0001);
    expect_val("zp_ab_next", 16'h0110);
`endif
    tick(); check({15'd0, bus.stall}); check(bus.AB);
    bus.fix_en = 1'b0;
    expect_val("zp_stall_end", 16'h0000);
    tick(); check({15'd0, bus.stall});

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
